// File: rtl/interrupt_dispatcher_pkg.sv
// Shared definitions for the interrupt dispatcher: cause codes written to r_k,
// scheduler configuration opcodes, and the dispatcher state encoding.
package interrupt_dispatcher_pkg;

  // Cause codes, written to r_k on kernel entry (0 means user mode)
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_SYS   = 2'd1;
  localparam logic [1:0] CAUSE_TIMER = 2'd2;
  localparam logic [1:0] CAUSE_DMA   = 2'd3;

  // Scheduler SCHED_OP configuration opcodes
  localparam logic [3:0] SCHED_SET_SYS     = 4'b0001;
  localparam logic [3:0] SCHED_SET_TIMER   = 4'b0010;
  localparam logic [3:0] SCHED_SET_OP      = 4'b0011;
  localparam logic [3:0] SCHED_INIT        = 4'b0100;
  localparam logic [3:0] SCHED_RESET_TIMER = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_VECTOR = 3'd2,
    ST_ACK    = 3'd3,
    ST_RETURN = 3'd4
  } state_e;

endpackage

// File: rtl/interrupt_dispatcher_priority_sel.sv
// int_priority_sel: combinational pick of the highest-priority pending source.
// Ports:
//   sys_req/timer_int/op_int  raw requests
//   mask_zero                 timer mask window has expired
//   rk_zero                   core is in user mode (no nesting otherwise)
//   int_pos/sys_int_pos/op_int_pos  vectors per source
//   pending/cause/vector      selected source
module int_priority_sel
  import interrupt_dispatcher_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              sys_req,
  input  logic              timer_int,
  input  logic              op_int,
  input  logic              mask_zero,
  input  logic              rk_zero,
  input  logic [DATA_W-1:0] int_pos,
  input  logic [DATA_W-1:0] sys_int_pos,
  input  logic [DATA_W-1:0] op_int_pos,
  output logic              pending,
  output logic [1:0]        cause,
  output logic [DATA_W-1:0] vector
);

  always_comb begin
    pending = 1'b0;
    cause   = CAUSE_NONE;
    vector  = '0;
    if (rk_zero) begin
      if (sys_req) begin
        pending = 1'b1;
        cause   = CAUSE_SYS;
        vector  = sys_int_pos;
      end else if (timer_int && mask_zero) begin
        pending = 1'b1;
        cause   = CAUSE_TIMER;
        vector  = int_pos;
      end else if (op_int) begin
        pending = 1'b1;
        cause   = CAUSE_DMA;
        vector  = op_int_pos;
      end
    end
  end

endmodule

// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: core-side responder for scheduler interrupts.
// Samples syscall/timer/DMA requests at instruction boundaries, saves the
// return PC, writes the cause to r_k, vectors the PC and handshakes back to
// the scheduler; also services return-from-interrupt.
// Ports:
//   clock, init_flag (async active-low reset)
//   inst_boundary, pc_next, sys_req, iret_req     from the pipeline
//   timer_int, op_int                             scheduler level flags
//   int_pos, sys_int_pos, op_int_pos, r_k         vectors and kernel reg
//   stall, pc_load, pc_value, rk_we, rk_wdata, epc   to the pipeline
//   sched_enb, sched_conf, sched_op, sched_value, dma_ack   to the scheduler
//   sys_fault                                     syscall-in-kernel pulse
module interrupt_dispatcher
  import interrupt_dispatcher_pkg::*;
#(
  parameter int DATA_W            = 16,
  parameter int TIMER_MASK_CYCLES = 4
) (
  input  logic              clock,
  input  logic              init_flag,
  input  logic              inst_boundary,
  input  logic [DATA_W-1:0] pc_next,
  input  logic              sys_req,
  input  logic              iret_req,
  input  logic              timer_int,
  input  logic              op_int,
  input  logic [DATA_W-1:0] int_pos,
  input  logic [DATA_W-1:0] sys_int_pos,
  input  logic [DATA_W-1:0] op_int_pos,
  input  logic [DATA_W-1:0] r_k,
  output logic              stall,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_value,
  output logic              rk_we,
  output logic [DATA_W-1:0] rk_wdata,
  output logic [DATA_W-1:0] epc,
  output logic              sched_enb,
  output logic              sched_conf,
  output logic [3:0]        sched_op,
  output logic [DATA_W-1:0] sched_value,
  output logic              dma_ack,
  output logic              sys_fault
);

  localparam int MASK_W = (TIMER_MASK_CYCLES < 2) ? 1 : $clog2(TIMER_MASK_CYCLES + 1);

  state_e              state, state_d;
  logic [1:0]          cause_q, cause_d;
  logic [DATA_W-1:0]   vec_q, vec_d, epc_d;
  logic [MASK_W-1:0]   mask_cnt;
  logic                mask_load;

  logic                stall_d, pc_load_d, rk_we_d, sched_en_d, dma_ack_d, sys_fault_d;
  logic [DATA_W-1:0]   pc_value_d, rk_wdata_d;

  logic                sel_pending;
  logic [1:0]          sel_cause;
  logic [DATA_W-1:0]   sel_vec;
  logic                rk_zero;

  assign rk_zero     = (r_k == '0);
  assign sched_value = '0;

  int_priority_sel #(.DATA_W(DATA_W)) u_sel (
    .sys_req     (sys_req),
    .timer_int   (timer_int),
    .op_int      (op_int),
    .mask_zero   (mask_cnt == '0),
    .rk_zero     (rk_zero),
    .int_pos     (int_pos),
    .sys_int_pos (sys_int_pos),
    .op_int_pos  (op_int_pos),
    .pending     (sel_pending),
    .cause       (sel_cause),
    .vector      (sel_vec)
  );

  // Outputs are registered on the edge that enters a state, so each state's
  // strobes are visible for exactly the cycle the FSM spends in that state.
  always_comb begin
    state_d     = state;
    cause_d     = cause_q;
    vec_d       = vec_q;
    epc_d       = epc;
    mask_load   = 1'b0;
    stall_d     = 1'b0;
    pc_load_d   = 1'b0;
    pc_value_d  = '0;
    rk_we_d     = 1'b0;
    rk_wdata_d  = '0;
    sched_en_d  = 1'b0;
    dma_ack_d   = 1'b0;
    sys_fault_d = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (inst_boundary) begin
          if (sel_pending) begin
            // entering SAVE: capture return PC, cause and vector once
            state_d = ST_SAVE;
            cause_d = sel_cause;
            vec_d   = sel_vec;
            epc_d   = pc_next;
            stall_d = 1'b1;
          end else if (!rk_zero && sys_req) begin
            sys_fault_d = 1'b1;
          end else if (!rk_zero && iret_req) begin
            state_d    = ST_RETURN;
            pc_load_d  = 1'b1;
            pc_value_d = epc;
            rk_we_d    = 1'b1;
            stall_d    = 1'b1;
          end
        end
      end
      ST_SAVE: begin
        state_d    = ST_VECTOR;
        pc_load_d  = 1'b1;
        pc_value_d = vec_q;
        rk_we_d    = 1'b1;
        rk_wdata_d = DATA_W'(cause_q);
        stall_d    = 1'b1;
      end
      ST_VECTOR: begin
        state_d = ST_ACK;
        stall_d = 1'b1;
        if (cause_q == CAUSE_TIMER) begin
          sched_en_d = 1'b1;
          mask_load  = 1'b1;
        end
        if (cause_q == CAUSE_DMA) dma_ack_d = 1'b1;
      end
      ST_ACK:    state_d = ST_IDLE;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      state      <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      vec_q      <= '0;
      epc        <= '0;
      mask_cnt   <= '0;
      stall      <= 1'b0;
      pc_load    <= 1'b0;
      pc_value   <= '0;
      rk_we      <= 1'b0;
      rk_wdata   <= '0;
      sched_enb  <= 1'b0;
      sched_conf <= 1'b0;
      sched_op   <= '0;
      dma_ack    <= 1'b0;
      sys_fault  <= 1'b0;
    end else begin
      state      <= state_d;
      cause_q    <= cause_d;
      vec_q      <= vec_d;
      epc        <= epc_d;
      // mask window hides the still-high timer flag while the scheduler clears it
      if (mask_load)            mask_cnt <= MASK_W'(TIMER_MASK_CYCLES);
      else if (mask_cnt != '0)  mask_cnt <= mask_cnt - 1'b1;
      stall      <= stall_d;
      pc_load    <= pc_load_d;
      pc_value   <= pc_value_d;
      rk_we      <= rk_we_d;
      rk_wdata   <= rk_wdata_d;
      sched_enb  <= sched_en_d;
      sched_conf <= sched_en_d;
      sched_op   <= sched_en_d ? SCHED_RESET_TIMER : 4'b0000;
      dma_ack    <= dma_ack_d;
      sys_fault  <= sys_fault_d;
    end
  end

endmodule

// File: tb/tb_interrupt_dispatcher.sv
module tb_interrupt_dispatcher;

  logic        clock, init_flag, inst_boundary, sys_req, iret_req, timer_int, op_int;
  logic [15:0] pc_next, int_pos, sys_int_pos, op_int_pos, r_k;
  logic        stall, pc_load, rk_we, sched_enb, sched_conf, dma_ack, sys_fault;
  logic [15:0] pc_value, rk_wdata, epc, sched_value;
  logic [3:0]  sched_op;

  int errors = 0;
  int checks = 0;

  interrupt_dispatcher #(.DATA_W(16), .TIMER_MASK_CYCLES(4)) dut (
    .clock(clock), .init_flag(init_flag), .inst_boundary(inst_boundary),
    .pc_next(pc_next), .sys_req(sys_req), .iret_req(iret_req),
    .timer_int(timer_int), .op_int(op_int), .int_pos(int_pos),
    .sys_int_pos(sys_int_pos), .op_int_pos(op_int_pos), .r_k(r_k),
    .stall(stall), .pc_load(pc_load), .pc_value(pc_value), .rk_we(rk_we),
    .rk_wdata(rk_wdata), .epc(epc), .sched_enb(sched_enb),
    .sched_conf(sched_conf), .sched_op(sched_op), .sched_value(sched_value),
    .dma_ack(dma_ack), .sys_fault(sys_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    init_flag = 1'b0;
    inst_boundary = 0; sys_req = 0; iret_req = 0; timer_int = 0; op_int = 0;
    pc_next = 16'h0; int_pos = 16'h0100; sys_int_pos = 16'h0200; op_int_pos = 16'h0300;
    r_k = 16'h0;
    repeat (2) @(posedge clock);
    #1 init_flag = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({stall, pc_load, rk_we, sched_enb, sched_conf, dma_ack, sys_fault} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {stall, pc_load, rk_we, sched_enb, sched_conf, dma_ack, sys_fault}); end
    checks++; if ({pc_value, rk_wdata, epc, sched_value, sched_op} !== 68'h0) begin
      errors++; $display("FAIL reset_values got pc=%h rk=%h epc=%h sv=%h op=%h exp 0", pc_value, rk_wdata, epc, sched_value, sched_op); end
  endtask

  task automatic test_timer_dispatch_and_mask();
    int stall_cnt;
    do_reset();
    pc_next = 16'h0040; timer_int = 1; inst_boundary = 1;
    stall_cnt = 0;
    tick();                                   // now in SAVE
    stall_cnt += int'(stall);
    checks++; if (epc !== 16'h0040) begin errors++; $display("FAIL timer_epc got %h exp 0040", epc); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL timer_save_noload got %b exp 0", pc_load); end
    inst_boundary = 0;
    tick();                                   // now in VECTOR
    stall_cnt += int'(stall);
    checks++; if ({pc_load, pc_value, rk_we, rk_wdata} !== {1'b1, 16'h0100, 1'b1, 16'h0002}) begin
      errors++; $display("FAIL timer_vector got load=%b pc=%h we=%b wd=%h exp 1 0100 1 0002", pc_load, pc_value, rk_we, rk_wdata); end
    r_k = 16'h0002;
    tick();                                   // now in ACK
    stall_cnt += int'(stall);
    checks++; if ({sched_enb, sched_conf, sched_op, sched_value, dma_ack, pc_load} !== {1'b1, 1'b1, 4'b0101, 16'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timer_ack got enb=%b conf=%b op=%b val=%h dma=%b exp 1 1 0101 0000 0", sched_enb, sched_conf, sched_op, sched_value, dma_ack); end
    tick();                                   // back in IDLE
    stall_cnt += int'(stall);
    checks++; if (stall_cnt != 3) begin errors++; $display("FAIL timer_stall_len got %0d exp 3", stall_cnt); end
    checks++; if (sched_enb !== 1'b0) begin errors++; $display("FAIL timer_ack_pulse got %b exp 0", sched_enb); end
    // timer still high; return from the handler while the mask is running
    iret_req = 1; inst_boundary = 1;
    tick();                                   // RETURN
    checks++; if ({pc_load, pc_value, rk_we, rk_wdata} !== {1'b1, 16'h0040, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL mask_iret got load=%b pc=%h we=%b wd=%h exp 1 0040 1 0000", pc_load, pc_value, rk_we, rk_wdata); end
    iret_req = 0; r_k = 16'h0; pc_next = 16'h0050;
    tick();                                   // RETURN -> IDLE
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mask_after_return got %b exp 0", stall); end
    tick();                                   // mask still 1 at this boundary
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mask_blocks_timer got stall=%b exp 0", stall); end
    tick();                                   // mask expired: re-dispatch
    checks++; if ({stall, epc} !== {1'b1, 16'h0050}) begin
      errors++; $display("FAIL mask_redispatch got stall=%b epc=%h exp 1 0050", stall, epc); end
    inst_boundary = 0; timer_int = 0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    do_reset();
    sys_req = 1; timer_int = 1; op_int = 1; inst_boundary = 1; pc_next = 16'h0080;
    tick();
    sys_req = 0; inst_boundary = 0;
    sys_int_pos = 16'h0BAD;                   // must not affect the dispatch in flight
    tick();
    checks++; if ({pc_value, rk_wdata} !== {16'h0200, 16'h0001}) begin
      errors++; $display("FAIL prio_sys got pc=%h wd=%h exp 0200 0001", pc_value, rk_wdata); end
    tick();
    checks++; if ({stall, sched_enb, sched_conf, dma_ack} !== 4'b1000) begin
      errors++; $display("FAIL prio_no_handshake got stall/enb/conf/dma=%b exp 1000", {stall, sched_enb, sched_conf, dma_ack}); end
    timer_int = 0; op_int = 0;
    tick();
  endtask

  task automatic test_kernel_blocking();
    do_reset();
    sys_req = 1; inst_boundary = 1; pc_next = 16'h0040;
    tick();
    sys_req = 0; inst_boundary = 0;
    repeat (3) tick();
    r_k = 16'h0002; op_int = 1; inst_boundary = 1;
    tick();
    checks++; if ({stall, pc_load} !== 2'b00) begin errors++; $display("FAIL kern_no_nest got stall/load=%b exp 00", {stall, pc_load}); end
    sys_req = 1; iret_req = 1;                // sys wins over iret -> fault only
    tick();
    checks++; if ({sys_fault, stall} !== 2'b10) begin errors++; $display("FAIL kern_sys_fault got fault/stall=%b exp 10", {sys_fault, stall}); end
    sys_req = 0;
    tick();                                   // iret alone now -> RETURN
    checks++; if ({sys_fault, pc_load, pc_value, rk_we, rk_wdata} !== {1'b0, 1'b1, 16'h0040, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL kern_iret got fault=%b load=%b pc=%h we=%b wd=%h exp 0 1 0040 1 0000", sys_fault, pc_load, pc_value, rk_we, rk_wdata); end
    iret_req = 0; r_k = 16'h0; inst_boundary = 0;
    tick();
    inst_boundary = 1; pc_next = 16'h0044;
    tick();
    checks++; if ({stall, epc} !== {1'b1, 16'h0044}) begin errors++; $display("FAIL dma_entry got stall=%b epc=%h exp 1 0044", stall, epc); end
    inst_boundary = 0;
    tick();
    checks++; if ({pc_value, rk_wdata} !== {16'h0300, 16'h0003}) begin
      errors++; $display("FAIL dma_vector got pc=%h wd=%h exp 0300 0003", pc_value, rk_wdata); end
    tick();
    checks++; if ({dma_ack, sched_enb} !== 2'b10) begin errors++; $display("FAIL dma_ack got ack/enb=%b exp 10", {dma_ack, sched_enb}); end
    op_int = 0;
    tick();
    checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_pulse got %b exp 0", dma_ack); end
  endtask

  task automatic test_async_reset();
    do_reset();
    timer_int = 1; inst_boundary = 1; pc_next = 16'h0040;
    tick();
    inst_boundary = 0; timer_int = 0;
    tick();                                   // in VECTOR, pc_load high
    #2 init_flag = 0;
    #1;
    checks++; if ({pc_load, stall, rk_we, epc} !== {3'b000, 16'h0}) begin
      errors++; $display("FAIL areset_now got load/stall/we=%b epc=%h exp 000 0000", {pc_load, stall, rk_we}, epc); end
    #1 init_flag = 1;
    tick();
    checks++; if ({pc_load, stall, sched_enb} !== 3'b000) begin errors++; $display("FAIL areset_after1 got %b exp 000", {pc_load, stall, sched_enb}); end
    tick();
    checks++; if ({pc_load, stall} !== 2'b00) begin errors++; $display("FAIL areset_after2 got %b exp 00", {pc_load, stall}); end
    op_int = 1; inst_boundary = 1; pc_next = 16'h0060;
    tick();
    checks++; if ({stall, epc} !== {1'b1, 16'h0060}) begin errors++; $display("FAIL areset_idle got stall=%b epc=%h exp 1 0060", stall, epc); end
    op_int = 0; inst_boundary = 0;
    repeat (3) tick();
  endtask

  task automatic test_boundary_gating();
    int early = 0;
    do_reset();
    timer_int = 1; pc_next = 16'h0070;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (stall !== 1'b0 || epc !== 16'h0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL gate_no_boundary got %0d early cycles exp 0", early); end
    inst_boundary = 1;
    tick();
    checks++; if ({stall, epc} !== {1'b1, 16'h0070}) begin errors++; $display("FAIL gate_boundary got stall=%b epc=%h exp 1 0070", stall, epc); end
    inst_boundary = 0; timer_int = 0;
    repeat (3) tick();
  endtask

  initial begin
    init_flag = 1'b0;
    test_reset();
    test_timer_dispatch_and_mask();
    test_priority();
    test_kernel_blocking();
    test_async_reset();
    test_boundary_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
